// File: rtl/usart_rx_controller_if.sv
// ---------------------------------------------------------------------------
// usart_rx_controller_if
// CPU-side handshake between the USART receive sequencer and the USART
// register block.
//   rx_data     : last received character (DATA_BITS wide)
//   rx_valid    : rx_data holds a character the CPU has not consumed yet
//   parity_err  : parity status of the character in rx_data
//   frame_err   : stop-bit status of the character in rx_data
//   overrun_err : sticky, a character was overwritten before it was acked
//   rx_busy     : receiver is somewhere other than IDLE
//   rx_ack      : CPU has consumed rx_data
// The receiver uses the master modport, the register block the slave one.
// ---------------------------------------------------------------------------
interface usart_rx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 rx_busy;
    logic                 rx_ack;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_busy,
        output rx_ack
    );
endinterface

// File: rtl/usart_rx_controller.sv
// ---------------------------------------------------------------------------
// usart_rx_controller
// Receive-side sequencer of the USART. Synchronises the RX pin, finds the
// start-bit falling edge, times every bit from the oversampling tick,
// samples at mid-bit, assembles the character (LSB first), checks parity
// and stop, and presents the result through a valid/ack register with
// overrun detection.
// Ports:
//   CPU_Clk   : system clock, everything on its rising edge
//   CPU_Rst   : synchronous active-high reset
//   rx_enable : 0 holds the receiver in IDLE and drops a partial frame
//   baud_tick : one-clock pulse, OVERSAMPLE pulses per bit period
//   rx_in     : asynchronous serial line, idles high
//   cpu_if    : CPU-side handshake (usart_rx_controller_if.master)
// ---------------------------------------------------------------------------
module usart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                         CPU_Clk,
    input  logic                         CPU_Rst,
    input  logic                         rx_enable,
    input  logic                         baud_tick,
    input  logic                         rx_in,
    usart_rx_controller_if.master        cpu_if
);

    localparam int TW = $clog2(OVERSAMPLE + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_FULL = TW'(OVERSAMPLE);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 prev_q, prev_d;
    logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_fail_q, par_fail_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_err_q, overrun_err_d;
    logic                 rx_busy_q, rx_busy_d;

    logic                 rx_s;
    logic                 start_edge;
    logic [TW-1:0]        tick_inc;
    logic [BW-1:0]        bit_inc;

    assign rx_s       = sync2_q;
    assign start_edge = prev_q & ~sync2_q;
    assign tick_inc   = tick_cnt_q + 1'b1;
    assign bit_inc    = bit_cnt_q + 1'b1;

    // Next-state logic for the frame sequencer and the CPU-side register.
    // The ack is applied first so that a completion in the same cycle
    // re-asserts rx_valid without counting as an overrun.
    always_comb begin
        state_d       = state_q;
        sync1_d       = rx_in;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        par_fail_d    = par_fail_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        parity_err_d  = parity_err_q;
        frame_err_d   = frame_err_q;
        overrun_err_d = overrun_err_q;

        if (cpu_if.rx_ack && rx_valid_q) begin
            rx_valid_d    = 1'b0;
            overrun_err_d = 1'b0;
        end

        if (!rx_enable) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                // Half a bit in, the line must still be low or it was a glitch.
                START: begin
                    if (baud_tick) begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc == TICK_HALF) begin
                            if (rx_s) begin
                                state_d = IDLE;
                            end else begin
                                state_d    = DATA;
                                tick_cnt_d = '0;
                                bit_cnt_d  = '0;
                                par_fail_d = 1'b0;
                            end
                        end
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc == TICK_FULL) begin
                            tick_cnt_d = '0;
                            shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                            bit_cnt_d  = bit_inc;
                            if (bit_inc == BIT_LAST) begin
                                state_d = (PARITY_EN != 0) ? PARITY : STOP;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc == TICK_FULL) begin
                            tick_cnt_d = '0;
                            par_fail_d = ((^shreg_q) ^ rx_s) != 1'(PARITY_ODD);
                            state_d    = STOP;
                        end
                    end
                end
                // Stop sample completes the frame; a low stop bit may be a
                // break, so wait for the line to recover before re-arming.
                STOP: begin
                    if (baud_tick) begin
                        tick_cnt_d = tick_inc;
                        if (tick_inc == TICK_FULL) begin
                            tick_cnt_d   = '0;
                            rx_data_d    = shreg_q;
                            parity_err_d = par_fail_q;
                            frame_err_d  = ~rx_s;
                            rx_valid_d   = 1'b1;
                            if (rx_valid_q && !cpu_if.rx_ack) begin
                                overrun_err_d = 1'b1;
                            end
                            state_d = rx_s ? IDLE : WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rx_busy_d = (state_d != IDLE);
    end

    // All state, including the synchroniser, is registered here. The
    // synchroniser and previous-sample flop reset to the idle line level
    // so that reset itself never looks like a start edge.
    always_ff @(posedge CPU_Clk) begin
        if (CPU_Rst) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            prev_q        <= 1'b1;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            par_fail_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            rx_busy_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            par_fail_q    <= par_fail_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            rx_busy_q     <= rx_busy_d;
        end
    end

    assign cpu_if.rx_data     = rx_data_q;
    assign cpu_if.rx_valid    = rx_valid_q;
    assign cpu_if.parity_err  = parity_err_q;
    assign cpu_if.frame_err   = frame_err_q;
    assign cpu_if.overrun_err = overrun_err_q;
    assign cpu_if.rx_busy     = rx_busy_q;

endmodule

// File: doc/usart_rx_controller.md
Name: usart_rx_controller

Overview:
- Receive-side sequencer for the USART.
- Synchronises the asynchronous RX line and detects the start-bit falling edge internally.
- Times each bit from an external oversampling tick, samples at mid-bit, assembles the character and checks parity and stop.
- Hands the character to the CPU side through a valid/ack register with overrun detection. Sits between the RX pin and the USART register interface.

Parameters:
DATA_BITS, 8, character length in bits (5..9), LSB first on the line.
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4).
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (used only when PARITY_EN=1).

Ports:
CPU_Clk  input  1  system clock; all logic is on its rising edge.
CPU_Rst  input  1  reset; synchronous, active-high.
rx_enable  input  1  0 = receiver held in IDLE; aborts any frame in progress.
baud_tick  input  1  one-CPU_Clk-wide pulse, OVERSAMPLE pulses per bit.
rx_in  input  1  asynchronous serial line; idles high.
rx_ack  input  1  CPU has consumed rx_data.
rx_data  output  DATA_BITS  last received character.
rx_valid  output  1  rx_data holds an unconsumed character.
parity_err  output  1  parity status of the character in rx_data.
frame_err  output  1  stop-bit status of the character in rx_data.
overrun_err  output  1  sticky: a character was overwritten before it was acked.
rx_busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE, counters 0. Synchroniser flops and previous-sample register are preset to 1.
- rx_in passes a 2-flop synchroniser (rx_s). Falling edge = previous rx_s 1 and current rx_s 0. This is evaluated every CPU_Clk, not only on ticks.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. tick_cnt counts baud_tick pulses and bit_cnt counts data bits.
- IDLE: on a falling edge with rx_enable=1, go to START and clear tick_cnt.
- START: on the (OVERSAMPLE/2)-th tick, sample rx_s.
  - rx_s=1: false start, back to IDLE with no flags.
  - rx_s=0: clear tick_cnt and bit_cnt, go to DATA.
- DATA: every OVERSAMPLE-th tick, shift rx_s into the data register MSB side (LSB-first reception) and increment bit_cnt. After bit DATA_BITS, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: sample on the OVERSAMPLE-th tick. Error if XOR(data, parity bit) != PARITY_ODD. Go to STOP.
- STOP: sample on the OVERSAMPLE-th tick. This is the frame-completion event.
  - Load rx_data, parity_err and frame_err (frame_err = stop sample 0). Set rx_valid.
  - Stop sample 1: go to IDLE.
  - Stop sample 0 (framing error or break): go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. Prevents a break from re-triggering.
- Completion timing: outputs update on the CPU_Clk edge that registers the sampling tick. rx_valid is high the cycle after that tick.
- rx_ack with rx_valid=1 clears rx_valid and overrun_err next cycle. rx_ack with rx_valid=0 has no effect.
- Completion while rx_valid=1 and rx_ack=0: rx_data and error flags are overwritten, overrun_err is set and rx_valid stays 1.
- Completion and rx_ack in the same cycle: new data is loaded, rx_valid stays 1 and overrun_err is not set.
- rx_enable=0: next cycle state is IDLE and counters clear. A partial frame is discarded. rx_data, rx_valid and the error flags are kept.
- Reset mid-frame: immediate return to the reset state; no completion is reported.
- baud_tick while in IDLE or WAIT_IDLE is ignored.
- tick_cnt and bit_cnt widths are sized to hold OVERSAMPLE and DATA_BITS; no wrap within a frame.

Test Plan:
- All tests use OVERSAMPLE=16, baud_tick every 4 clocks, and 8N1 framing unless stated otherwise.
- Send 0xA5 with a valid stop bit -> rx_valid rises once. rx_data=0xA5, frame_err=0, parity_err=0. rx_busy returns to 0. rx_ack then clears rx_valid.
- Hold rx_in low for 5 ticks then return high -> START aborts at tick 8. No rx_valid and no flags. rx_busy=0 afterwards.
- Send 0x3C with stop bit 0, then hold the line low for 20 bits -> one completion with rx_data=0x3C and frame_err=1. FSM stays in WAIT_IDLE with no new start until the line returns high. A following 0x55 is received correctly.
- PARITY_EN=1, PARITY_ODD=0: send 0x03 with parity bit 1 -> parity_err=1. Send 0x03 with parity bit 0 -> parity_err=0.
- Send 0x11 (no ack), then 0x22 -> rx_data=0x22, overrun_err=1. rx_ack clears both rx_valid and overrun_err. Repeat with rx_ack asserted on the exact completion cycle of the second frame -> rx_valid=1, overrun_err=0.
- Assert CPU_Rst during bit 4 of a frame -> all outputs 0, no completion. Deassert rx_enable mid-frame -> no completion, and the prior rx_data is retained.
